// File: rtl/mux_pkg.sv
// Shared constants for the N-channel stream multiplexer: selection modes and FSM encodings.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    localparam logic [1:0] ST_FIXED = 2'd0;
    localparam logic [1:0] ST_RR    = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Steady state that corresponds to a given mode input.
    function automatic logic [1:0] mode_state(input logic mode);
        return (mode == MODE_RR) ? ST_RR : ST_FIXED;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: grants the first set request found searching cyclically from ptr+1.
module rr_pick
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_any
);

    int idx;

    // k runs 1..N so the channel at ptr itself is checked last.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with fixed-select and round-robin modes,
// a registered output stage, and a drain state so mode changes never lose or repeat a word.
module stream_mux_n
    import mux_pkg::*;
#(
    parameter  int WIDTH    = 3,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_any;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_any;
    logic             free;
    logic             accept;
    logic [WIDTH-1:0] grant_data;

    rr_pick #(.N(CHANNELS)) u_rr_pick (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign free = !out_valid || out_ready;

    // An out-of-range select (non-power-of-2 channel counts) grants nothing.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        case (state)
            ST_FIXED: begin
                if (int'(sel) < CHANNELS) begin
                    grant_idx = sel;
                    grant_any = 1'b1;
                end
            end
            ST_RR: begin
                grant_idx = rr_idx;
                grant_any = rr_any;
            end
            default: ;
        endcase
    end

    always_comb begin
        in_ready = '0;
        if (grant_any) in_ready[grant_idx] = free;
    end

    assign accept     = grant_any && free && in_valid[grant_idx];
    assign grant_data = in_data[int'(grant_idx) * WIDTH +: WIDTH];

    // DRAIN exits once the output slot empties or is consumed at this edge.
    always_comb begin
        state_next = state;
        case (state)
            ST_FIXED: if (mode != MODE_FIXED) state_next = ST_DRAIN;
            ST_RR:    if (mode != MODE_RR)    state_next = ST_DRAIN;
            default:  if (free)               state_next = mode_state(mode);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FIXED;
            rr_ptr    <= SEL_W'(CHANNELS - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else begin
            state <= state_next;
            if (accept && state == ST_RR) rr_ptr <= grant_idx;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_chan  <= grant_idx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// Scoreboard bench for stream_mux_n: directed vectors push expected words; a negedge monitor pops on each transfer.
module tb_stream_mux_n;
    import mux_pkg::*;

    typedef struct {
        logic [1:0] chan;
        logic [2:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [11:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [2:0]  out_data;
    logic [1:0]  out_chan;
    logic        out_valid;
    logic        out_ready;

    logic        mode2;
    logic [1:0]  sel2;
    logic [8:0]  in_data2;
    logic [2:0]  in_valid2;
    logic [2:0]  in_ready2;
    logic [2:0]  out_data2;
    logic [1:0]  out_chan2;
    logic        out_valid2;
    logic        out_ready2;

    exp_t sb_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    int rr_all[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
    int rr_odd[4]  = '{1, 3, 1, 3};
    int ch_val[4]  = '{1, 3, 5, 7};

    stream_mux_n #(.WIDTH(3), .CHANNELS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    stream_mux_n #(.WIDTH(3), .CHANNELS(3)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode2),
        .sel       (sel2),
        .in_data   (in_data2),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .out_data  (out_data2),
        .out_chan  (out_chan2),
        .out_valid (out_valid2),
        .out_ready (out_ready2)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic m, input logic [1:0] s, input logic [3:0] v, input logic r);
        mode      = m;
        sel       = s;
        in_valid  = v;
        out_ready = r;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input int chan, input int data);
        exp_t e;
        e.chan = 2'(chan);
        e.data = 3'(data);
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A word moves whenever out_valid && out_ready are seen mid-cycle.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_word", {29'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("sb_chan", {30'd0, out_chan}, {30'd0, e.chan});
                checkOutput("sb_data", {29'd0, out_data}, {29'd0, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_data   = {3'd7, 3'd5, 3'd3, 3'd1};
        applyStimulus(MODE_FIXED, 2'd2, 4'b1111, 1'b1);
        mode2      = MODE_FIXED;
        sel2       = 2'd0;
        in_data2   = {3'd6, 3'd4, 3'd2};
        in_valid2  = 3'b000;
        out_ready2 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] reset state and fixed select");
        @(negedge clk);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_data", {29'd0, out_data}, 32'd0);
        checkOutput("reset_out_chan", {30'd0, out_chan}, 32'd0);
        checkOutput("fixed_in_ready", {28'd0, in_ready}, 32'b0100);
        for (int k = 0; k < 3; k++) begin
            pushExpected(2, 5);
            if (k > 0) begin
                @(negedge clk);
                checkOutput("fixed_throughput", {31'd0, out_valid}, 32'd1);
            end
            tick();
        end
        applyStimulus(MODE_FIXED, 2'd2, 4'b0000, 1'b1);
        tick();
        tick();

        $display("[TB] backpressure");
        applyStimulus(MODE_FIXED, 2'd1, 4'b1111, 1'b1);
        pushExpected(1, 3);
        @(negedge clk);
        checkOutput("bp_in_ready_free", {28'd0, in_ready}, 32'b0010);
        tick();
        applyStimulus(MODE_FIXED, 2'd1, 4'b1111, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_out_data", {29'd0, out_data}, 32'd3);
            checkOutput("bp_out_chan", {30'd0, out_chan}, 32'd1);
            checkOutput("bp_in_ready", {28'd0, in_ready}, 32'd0);
            tick();
        end
        in_data = {3'd7, 3'd5, 3'd6, 3'd1};
        applyStimulus(MODE_FIXED, 2'd1, 4'b1111, 1'b1);
        pushExpected(1, 6);
        @(negedge clk);
        checkOutput("bp_resume_ready", {28'd0, in_ready}, 32'b0010);
        tick();
        applyStimulus(MODE_FIXED, 2'd1, 4'b0000, 1'b1);
        in_data = {3'd7, 3'd5, 3'd3, 3'd1};
        tick();
        tick();

        $display("[TB] mode switch with stalled output");
        applyStimulus(MODE_FIXED, 2'd1, 4'b1111, 1'b1);
        pushExpected(1, 3);
        tick();
        applyStimulus(MODE_RR, 2'd1, 4'b1111, 1'b0);
        @(negedge clk);
        checkOutput("sw_stall_ready", {28'd0, in_ready}, 32'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("sw_state_drain", {30'd0, dut.state}, {30'd0, ST_DRAIN});
            checkOutput("sw_drain_ready", {28'd0, in_ready}, 32'd0);
            checkOutput("sw_held_chan", {30'd0, out_chan}, 32'd1);
            tick();
        end
        applyStimulus(MODE_RR, 2'd1, 4'b1111, 1'b1);
        @(negedge clk);
        checkOutput("sw_drain_exit_ready", {28'd0, in_ready}, 32'd0);
        tick();

        $display("[TB] round-robin fairness");
        for (int k = 0; k < 8; k++) begin
            pushExpected(rr_all[k], ch_val[rr_all[k]]);
            @(negedge clk);
            checkOutput("rr_all_ready", {28'd0, in_ready}, 32'd1 << rr_all[k]);
            tick();
        end
        applyStimulus(MODE_RR, 2'd1, 4'b1010, 1'b1);
        for (int k = 0; k < 4; k++) begin
            pushExpected(rr_odd[k], ch_val[rr_odd[k]]);
            @(negedge clk);
            checkOutput("rr_odd_ready", {28'd0, in_ready}, 32'd1 << rr_odd[k]);
            tick();
        end

        $display("[TB] round-robin pointer hold");
        applyStimulus(MODE_RR, 2'd1, 4'b1000, 1'b1);
        pushExpected(3, 7);
        @(negedge clk);
        checkOutput("ptr_single3", {28'd0, in_ready}, 32'b1000);
        tick();
        applyStimulus(MODE_RR, 2'd1, 4'b1001, 1'b1);
        pushExpected(0, 1);
        @(negedge clk);
        checkOutput("ptr_wrap0", {28'd0, in_ready}, 32'b0001);
        tick();
        applyStimulus(MODE_RR, 2'd1, 4'b1001, 1'b0);
        @(negedge clk);
        checkOutput("ptr_stall_ready", {28'd0, in_ready}, 32'd0);
        tick();
        applyStimulus(MODE_RR, 2'd1, 4'b1001, 1'b1);
        pushExpected(3, 7);
        @(negedge clk);
        checkOutput("ptr_then3", {28'd0, in_ready}, 32'b1000);
        tick();
        applyStimulus(MODE_RR, 2'd1, 4'b0000, 1'b1);
        tick();
        tick();

        $display("[TB] reset mid-operation");
        applyStimulus(MODE_RR, 2'd1, 4'b0100, 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_ready", {28'd0, in_ready}, 32'b0100);
        tick();
        applyStimulus(MODE_RR, 2'd1, 4'b0000, 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("pre_rst_chan", {30'd0, out_chan}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_data", {29'd0, out_data}, 32'd0);
        checkOutput("rst_out_chan", {30'd0, out_chan}, 32'd0);
        tick();
        tick();
        applyStimulus(MODE_RR, 2'd1, 4'b1111, 1'b1);
        pushExpected(0, 1);
        @(negedge clk);
        checkOutput("rst_first_rr", {28'd0, in_ready}, 32'b0001);
        tick();
        applyStimulus(MODE_RR, 2'd1, 4'b0000, 1'b1);
        tick();
        tick();

        $display("[TB] invalid select with three channels");
        sel2      = 2'd3;
        in_valid2 = 3'b111;
        @(negedge clk);
        checkOutput("sel3_in_ready", {29'd0, in_ready2}, 32'd0);
        tick();
        @(negedge clk);
        checkOutput("sel3_no_accept", {31'd0, out_valid2}, 32'd0);
        sel2 = 2'd2;
        @(negedge clk);
        checkOutput("sel2_in_ready", {29'd0, in_ready2}, 32'b100);
        tick();
        @(negedge clk);
        checkOutput("sel2_out_valid", {31'd0, out_valid2}, 32'd1);
        checkOutput("sel2_out_data", {29'd0, out_data2}, 32'd6);
        checkOutput("sel2_out_chan", {30'd0, out_chan2}, 32'd2);
        in_valid2 = 3'b000;
        tick();

        checkOutput("sb_leftover", sb_q.size(), 32'd0);
        checkOutput("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/stream_mux_n.md
Name: stream_mux_n

Overview:
- Parametrised N-channel, W-bit multiplexer; successor to the fixed 4:1 select mux.
- Adds per-channel valid/ready handshakes, a registered output stage, and two selection modes:
  - fixed select, driven by `sel`
  - round-robin arbitration across valid channels.
- Sits between multiple producers and one consumer in lab datapaths.
- Mode changes are drained safely: no word is lost and no word is duplicated.

Parameters:
- WIDTH, 3, data width per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, $clog2(CHANNELS), width of `sel` and `out_chan` (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- in_data  in  CHANNELS*WIDTH  packed inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_ready  out  CHANNELS  per-channel ready (combinational).
- out_data  out  WIDTH  registered output data.
- out_chan  out  SEL_W  registered index of the source channel of out_data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  consumer ready.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_data=0, out_chan=0.
  - rr_ptr=CHANNELS-1, so the first round-robin search starts at channel 0.
  - FSM state=FIXED.
- Slot availability: free = !out_valid || out_ready.
- Handshakes:
  - Accept on channel i when in_valid[i] && in_ready[i].
  - At most one channel is accepted per cycle.
  - Latency is 1 cycle: the accepted word appears on out_data/out_chan/out_valid at the next edge.
- Output register:
  - If out_valid && out_ready with no accept, out_valid goes to 0; out_data and out_chan hold their values.
  - A simultaneous drain and accept gives full throughput: 1 word per cycle.
  - While out_valid && !out_ready, out_data and out_chan hold stable and all in_ready are 0.
- FSM states: FIXED, RR, DRAIN.
  - FIXED: grant = sel; in_ready[sel] = free; all other in_ready = 0.
    - sel >= CHANNELS (non-power-of-2 CHANNELS): no grant, all in_ready = 0.
    - sel changes take effect in the same cycle.
  - RR: grant = first i with in_valid[i]=1, searching cyclically from rr_ptr+1.
    - in_ready[grant] = free.
    - rr_ptr <= grant on accept only; otherwise rr_ptr holds.
    - No valid inputs: all in_ready = 0.
  - Transitions FIXED->DRAIN and RR->DRAIN occur when mode differs from the current state's mode.
  - DRAIN:
    - All in_ready = 0.
    - Move to the state selected by mode once out_valid=0, or once out_valid && out_ready at this edge.
    - If mode toggles back while in DRAIN, still exit to the state matching the current mode.
    - rr_ptr is preserved across mode switches.
- Reset mid-transfer: the word in the output register is discarded (out_valid=0 next cycle), and rr_ptr and the FSM are reinitialised.
- Handshake rules:
  - in_ready may depend on in_valid (arbiter).
  - out_valid never depends combinationally on out_ready.

Decomposition:
- Package mux_pkg:
  - MODE_FIXED=1'b0, MODE_RR=1'b1.
  - FSM encodings ST_FIXED=2'd0, ST_RR=2'd1, ST_DRAIN=2'd2.
- Sub-module rr_pick: combinational rotating-priority picker.
  - Parameter N.
  - Inputs: req[N], ptr[SEL_W].
  - Outputs: gnt_idx[SEL_W], gnt_any.
  - Instantiated once in stream_mux_n.

Test Plan:
1. Reset then fixed mode:
   - Stimulus: WIDTH=3, CHANNELS=4, mode=0, sel=2, in_valid=4'b1111, in_data={3'd7,3'd5,3'd3,3'd1}, out_ready=1.
   - Required response: in_ready=4'b0100; next cycle out_data=5, out_chan=2, out_valid=1; one word per cycle thereafter.
2. Backpressure:
   - Stimulus: fixed sel=1, out_ready=0 for 3 cycles after the first accept.
   - Required response: out_data=3 and out_chan=1 held stable; in_ready=0 during the stall; resumes on the first out_ready=1 cycle with no loss or duplication.
3. Round-robin fairness:
   - Stimulus: mode=1, all in_valid=1, out_ready=1.
   - Required response: out_chan sequence 0,1,2,3,0,1...
   - Stimulus: then in_valid=4'b1010.
   - Required response: out_chan alternates 1,3,1,3.
4. Round-robin pointer hold:
   - Stimulus: single request on channel 3, then requests on 0 and 3 together.
   - Required response: grant goes to 0 (search starts at 3+1 wraps to 0), then 3.
5. Mode switch with stalled output:
   - Stimulus: mode 0->1 while out_valid=1 and out_ready=0.
   - Required response: FSM in DRAIN; all in_ready=0 until out_ready=1; first round-robin accept occurs the cycle after the drain; no word dropped.
6. Reset mid-operation and invalid select:
   - Stimulus: assert rst with out_valid=1.
   - Required response: next cycle out_valid=0, out_data=0, out_chan=0; first round-robin grant goes to channel 0.
   - Stimulus: CHANNELS=3 with sel=3.
   - Required response: in_ready=0.
